// File: rtl/riscv_pkg.sv
// Shared pipeline types: write-back source select, load funct3 codes and
// writeback-stage FSM states, plus the load sign/zero-extension helpers.
package riscv_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_RSV = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    EMPTY     = 2'b00,
    ACTIVE    = 2'b01,
    LOAD_WAIT = 2'b10
  } wb_state_e;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Execute-to-writeback bundle: incoming instruction fields, data-memory
// response, and the write-back / stall / error results.
interface writeback_stage_if;
  logic        ex_valid;
  logic        ex_flush;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rd;
  logic        ex_reg_wr;
  logic [1:0]  ex_wb_sel;
  logic        ex_mem_rd;
  logic [2:0]  ex_funct3;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic        reg_wr;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        load_err;

  modport master (
    output ex_valid, ex_flush, ex_alu_result, ex_pc, ex_rd, ex_reg_wr,
           ex_wb_sel, ex_mem_rd, ex_funct3, dmem_rvalid, dmem_rdata,
    input  stall, reg_wr, waddr, wdata, load_err
  );

  modport slave (
    input  ex_valid, ex_flush, ex_alu_result, ex_pc, ex_rd, ex_reg_wr,
           ex_wb_sel, ex_mem_rd, ex_funct3, dmem_rvalid, dmem_rdata,
    output stall, reg_wr, waddr, wdata, load_err
  );
endinterface

// File: rtl/writeback_stage_load_align.sv
// Combinational load alignment: picks the byte/halfword at the address
// offset, extends it, and flags misaligned halfword/word accesses.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select lane, then extend according to load type
  always_comb begin
    byte_s     = 8'h00;
    half_s     = 16'h0000;
    data       = 32'h0000_0000;
    misaligned = 1'b0;
    case (offset)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (offset[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (funct3)
      F3_LB:   data = ext8(byte_s, 1'b1);
      F3_LBU:  data = ext8(byte_s, 1'b0);
      F3_LH: begin
        data       = ext16(half_s, 1'b1);
        misaligned = offset[0];
      end
      F3_LHU: begin
        data       = ext16(half_s, 1'b0);
        misaligned = offset[0];
      end
      default: begin
        data       = rdata;
        misaligned = (offset != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Execute->writeback pipeline register, load-wait FSM with timeout, and the
// write-back mux feeding the register file and the forwarding network.
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16,
  parameter int TO_W         = 5
) (
  input  logic             clk,
  input  logic             rst,
  writeback_stage_if.slave wb
);

  wb_state_e        state_r;
  logic             valid_r;
  logic [31:0]      alu_r;
  logic [31:0]      pc_r;
  logic [4:0]       rd_r;
  logic             held_wr_r;
  wb_sel_e          wb_sel_r;
  logic             mem_rd_r;
  logic [2:0]       funct3_r;
  logic [TO_W-1:0]  count_r;
  logic             load_err_r;

  logic             load_wait_s;
  logic             timeout_s;
  logic             stall_s;
  logic             err_s;
  logic             reg_wr_s;
  logic             misaligned_s;
  logic             cap_valid_s;
  logic [31:0]      mem_data_s;
  logic [31:0]      wdata_s;

  load_align u_align (
    .rdata      (wb.dmem_rdata),
    .offset     (alu_r[1:0]),
    .funct3     (funct3_r),
    .data       (mem_data_s),
    .misaligned (misaligned_s)
  );

  assign load_wait_s = (state_r == LOAD_WAIT);
  assign timeout_s   = (count_r >= TO_W'(LOAD_TIMEOUT));
  assign stall_s     = load_wait_s & ~wb.dmem_rvalid & ~timeout_s;
  assign err_s       = load_wait_s & ((wb.dmem_rvalid & misaligned_s) |
                                      (~wb.dmem_rvalid & timeout_s));
  assign reg_wr_s    = valid_r & held_wr_r & (rd_r != 5'd0) & ~err_s &
                       (~mem_rd_r | (load_wait_s & wb.dmem_rvalid));
  assign cap_valid_s = wb.ex_valid & ~wb.ex_flush;

  // Write-back source select; kept unregistered so a late dmem_rdata still
  // settles before the register file's negedge write
  always_comb begin
    wdata_s = 32'h0000_0000;
    if (reg_wr_s) begin
      case (wb_sel_r)
        WB_ALU:  wdata_s = alu_r;
        WB_MEM:  wdata_s = mem_data_s;
        WB_PC4:  wdata_s = pc_r + 32'd4;
        default: wdata_s = 32'h0000_0000;
      endcase
    end else begin
      wdata_s = 32'h0000_0000;
    end
  end

  // Pipeline register, FSM and timeout counter; held instruction is frozen while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= EMPTY;
      valid_r    <= 1'b0;
      alu_r      <= 32'h0000_0000;
      pc_r       <= 32'h0000_0000;
      rd_r       <= 5'd0;
      held_wr_r  <= 1'b0;
      wb_sel_r   <= WB_ALU;
      mem_rd_r   <= 1'b0;
      funct3_r   <= 3'b000;
      count_r    <= '0;
      load_err_r <= 1'b0;
    end else begin
      load_err_r <= load_err_r | err_s;
      if (!stall_s) begin
        valid_r   <= cap_valid_s;
        alu_r     <= wb.ex_alu_result;
        pc_r      <= wb.ex_pc;
        rd_r      <= wb.ex_rd;
        held_wr_r <= wb.ex_reg_wr;
        wb_sel_r  <= wb_sel_e'(wb.ex_wb_sel);
        mem_rd_r  <= wb.ex_mem_rd;
        funct3_r  <= wb.ex_funct3;
        count_r   <= '0;
        if (!cap_valid_s) begin
          state_r <= EMPTY;
        end else if (wb.ex_mem_rd) begin
          state_r <= LOAD_WAIT;
        end else begin
          state_r <= ACTIVE;
        end
      end else begin
        count_r <= count_r + TO_W'(1);
      end
    end
  end

  assign wb.stall    = stall_s;
  assign wb.reg_wr   = reg_wr_s;
  assign wb.waddr    = rd_r;
  assign wb.wdata    = wdata_s;
  assign wb.load_err = load_err_r;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage: ALU/load/PC+4 retirement,
// load stalls and timeout, misalignment, flush and asynchronous reset.
module tb_writeback_stage;

  logic clk;
  logic rst;
  int   n_asserts;
  int   n_fail;
  int   stall_cnt;

  writeback_stage_if wb_if ();

  writeback_stage #(.LOAD_TIMEOUT(16), .TO_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic fl, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [4:0] rd, input logic rw,
                         input logic [1:0] sel, input logic mr, input logic [2:0] f3);
    wb_if.ex_valid      = v;
    wb_if.ex_flush      = fl;
    wb_if.ex_alu_result = alu;
    wb_if.ex_pc         = pc;
    wb_if.ex_rd         = rd;
    wb_if.ex_reg_wr     = rw;
    wb_if.ex_wb_sel     = sel;
    wb_if.ex_mem_rd     = mr;
    wb_if.ex_funct3     = f3;
  endtask

  task automatic bubble();
    present(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 3'b000);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bubble();
    wb_if.dmem_rvalid = 1'b0;
    wb_if.dmem_rdata  = 32'h0;
    #12;
    chk("rst_stall", {31'd0, wb_if.stall}, 32'd0);
    chk("rst_reg_wr", {31'd0, wb_if.reg_wr}, 32'd0);
    chk("rst_waddr", {27'd0, wb_if.waddr}, 32'd0);
    chk("rst_wdata", wb_if.wdata, 32'd0);
    chk("rst_load_err", {31'd0, wb_if.load_err}, 32'd0);
    rst = 1'b0;

    // ADD rd=5 -> 0xA5
    present(1'b1, 1'b0, 32'h0000_00A5, 32'h100, 5'd5, 1'b1, 2'b00, 1'b0, 3'b000);
    tick();
    bubble();
    chk("add_reg_wr", {31'd0, wb_if.reg_wr}, 32'd1);
    chk("add_waddr", {27'd0, wb_if.waddr}, 32'd5);
    chk("add_wdata", wb_if.wdata, 32'h0000_00A5);
    chk("add_stall", {31'd0, wb_if.stall}, 32'd0);

    // LB offset 3, data after two stall cycles, younger ADD waiting upstream
    present(1'b1, 1'b0, 32'h0000_1003, 32'h104, 5'd7, 1'b1, 2'b01, 1'b1, 3'b000);
    tick();
    present(1'b1, 1'b0, 32'h0000_0011, 32'h108, 5'd8, 1'b1, 2'b00, 1'b0, 3'b000);
    chk("lb_stall0", {31'd0, wb_if.stall}, 32'd1);
    chk("lb_nowr0", {31'd0, wb_if.reg_wr}, 32'd0);
    tick();
    chk("lb_stall1", {31'd0, wb_if.stall}, 32'd1);
    wb_if.dmem_rvalid = 1'b1;
    wb_if.dmem_rdata  = 32'h80FF_FF00;
    #1;
    chk("lb_stall_rv", {31'd0, wb_if.stall}, 32'd0);
    chk("lb_reg_wr", {31'd0, wb_if.reg_wr}, 32'd1);
    chk("lb_waddr", {27'd0, wb_if.waddr}, 32'd7);
    chk("lb_wdata", wb_if.wdata, 32'hFFFF_FF80);
    tick();
    wb_if.dmem_rvalid = 1'b0;
    #1;
    chk("lb_next_waddr", {27'd0, wb_if.waddr}, 32'd8);
    chk("lb_next_wdata", wb_if.wdata, 32'h0000_0011);

    // LHU offset 2 with immediate data, then LH offset 1 misaligned
    present(1'b1, 1'b0, 32'h0000_2002, 32'h10C, 5'd9, 1'b1, 2'b01, 1'b1, 3'b101);
    tick();
    wb_if.dmem_rvalid = 1'b1;
    wb_if.dmem_rdata  = 32'hBEEF_1234;
    present(1'b1, 1'b0, 32'h0000_2001, 32'h110, 5'd10, 1'b1, 2'b01, 1'b1, 3'b001);
    #1;
    chk("lhu_stall", {31'd0, wb_if.stall}, 32'd0);
    chk("lhu_reg_wr", {31'd0, wb_if.reg_wr}, 32'd1);
    chk("lhu_wdata", wb_if.wdata, 32'h0000_BEEF);
    tick();
    bubble();
    #1;
    chk("lh_mis_reg_wr", {31'd0, wb_if.reg_wr}, 32'd0);
    chk("lh_mis_wdata", wb_if.wdata, 32'd0);
    chk("lh_mis_stall", {31'd0, wb_if.stall}, 32'd0);
    chk("lh_err_pre", {31'd0, wb_if.load_err}, 32'd0);
    tick();
    wb_if.dmem_rvalid = 1'b0;
    chk("lh_err_set", {31'd0, wb_if.load_err}, 32'd1);

    // Timeout: fresh reset, LW that never gets data
    pulse_reset();
    chk("to_err_clr", {31'd0, wb_if.load_err}, 32'd0);
    present(1'b1, 1'b0, 32'h0000_3000, 32'h200, 5'd11, 1'b1, 2'b01, 1'b1, 3'b010);
    tick();
    bubble();
    stall_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!wb_if.stall) break;
      stall_cnt++;
      tick();
    end
    chk("to_stall_cycles", stall_cnt, 32'd16);
    chk("to_reg_wr", {31'd0, wb_if.reg_wr}, 32'd0);
    chk("to_stall_end", {31'd0, wb_if.stall}, 32'd0);
    tick();
    chk("to_err_set", {31'd0, wb_if.load_err}, 32'd1);

    // PC+4: rd=0 suppressed, rd=1 wraps, plain increment, reserved select
    present(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC, 5'd0, 1'b1, 2'b10, 1'b0, 3'b000);
    tick();
    present(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC, 5'd1, 1'b1, 2'b10, 1'b0, 3'b000);
    chk("jal_rd0_reg_wr", {31'd0, wb_if.reg_wr}, 32'd0);
    tick();
    present(1'b1, 1'b0, 32'h0, 32'h0000_0100, 5'd4, 1'b1, 2'b10, 1'b0, 3'b000);
    chk("jal_wrap_reg_wr", {31'd0, wb_if.reg_wr}, 32'd1);
    chk("jal_wrap_wdata", wb_if.wdata, 32'h0000_0000);
    tick();
    present(1'b1, 1'b0, 32'h1234_5678, 32'h0, 5'd2, 1'b1, 2'b11, 1'b0, 3'b000);
    chk("jal_pc4_wdata", wb_if.wdata, 32'h0000_0104);
    tick();
    chk("rsv_reg_wr", {31'd0, wb_if.reg_wr}, 32'd1);
    chk("rsv_wdata", wb_if.wdata, 32'h0000_0000);

    // Flush on a free cycle captures a bubble
    present(1'b1, 1'b1, 32'h0000_0077, 32'h0, 5'd3, 1'b1, 2'b00, 1'b0, 3'b000);
    tick();
    chk("flush_bubble_wr", {31'd0, wb_if.reg_wr}, 32'd0);

    // Flush while a load waits does not kill the held load
    present(1'b1, 1'b0, 32'h0000_4000, 32'h0, 5'd12, 1'b1, 2'b01, 1'b1, 3'b010);
    tick();
    present(1'b1, 1'b1, 32'h0000_0055, 32'h0, 5'd6, 1'b1, 2'b00, 1'b0, 3'b000);
    chk("flw_stall", {31'd0, wb_if.stall}, 32'd1);
    tick();
    wb_if.dmem_rvalid = 1'b1;
    wb_if.dmem_rdata  = 32'hCAFE_F00D;
    #1;
    chk("flw_reg_wr", {31'd0, wb_if.reg_wr}, 32'd1);
    chk("flw_waddr", {27'd0, wb_if.waddr}, 32'd12);
    chk("flw_wdata", wb_if.wdata, 32'hCAFE_F00D);
    tick();
    wb_if.dmem_rvalid = 1'b0;
    bubble();
    chk("flw_after_wr", {31'd0, wb_if.reg_wr}, 32'd0);

    // Reset pulse in the middle of a load wait drops the load
    present(1'b1, 1'b0, 32'h0000_5000, 32'h0, 5'd13, 1'b1, 2'b01, 1'b1, 3'b010);
    tick();
    bubble();
    chk("rstlw_stall_pre", {31'd0, wb_if.stall}, 32'd1);
    wb_if.dmem_rvalid = 1'b1;
    wb_if.dmem_rdata  = 32'h1111_2222;
    rst = 1'b1;
    #1;
    chk("rstlw_stall", {31'd0, wb_if.stall}, 32'd0);
    chk("rstlw_reg_wr", {31'd0, wb_if.reg_wr}, 32'd0);
    chk("rstlw_err", {31'd0, wb_if.load_err}, 32'd0);
    rst = 1'b0;
    tick();
    wb_if.dmem_rvalid = 1'b0;
    chk("rstlw_post_wr", {31'd0, wb_if.reg_wr}, 32'd0);
    chk("rstlw_post_stall", {31'd0, wb_if.stall}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
